// File: rtl/dmem_arbiter_if.sv
// One requester port of the dmem arbiter: request, access attributes and completion.
// master = requester (memory stage or loader), slave = arbiter.
// req/we/addr/wdata held stable until the one-cycle ack; rdata/err valid with ack.
interface dmem_arbiter_if;
  logic        req;
  logic        we;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic        ack;
  logic [63:0] rdata;
  logic        err;

  modport master (output req, we, addr, wdata, input  ack, rdata, err);
  modport slave  (input  req, we, addr, wdata, output ack, rdata, err);
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single-ported dmem between port C (memory stage) and port L (loader).
// Latency: req sampled in IDLE, one ACCESS cycle, ack during RESP (3 cycles, 1 txn / 3 cycles).
// Backpressure: requesters hold req until ack; the losing port simply waits in IDLE.
// Ports: clk, rst_n (async active-low); c/l requester interfaces; mem_addr/read_addr/mem_data/
//        mem_write toward dmem; read_data/dmem_err back from dmem (both combinational).
module dmem_arbiter #(
  parameter bit CPU_PRIORITY = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave c,
  dmem_arbiter_if.slave l,
  output logic [63:0]   mem_addr,
  output logic [63:0]   read_addr,
  output logic [63:0]   mem_data,
  output logic          mem_write,
  input  logic [63:0]   read_data,
  input  logic          dmem_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  localparam logic PORT_C = 1'b0;
  localparam logic PORT_L = 1'b1;

  state_t      state;
  logic        owner;
  logic        last_grant;
  logic        lat_we;
  logic [63:0] lat_addr;
  logic [63:0] lat_wdata;
  logic [63:0] c_rdata_q;
  logic [63:0] l_rdata_q;
  logic        c_err_q;
  logic        l_err_q;
  logic        grant_l;

  // L wins when it is alone, or on a tie under round-robin when C had the last grant.
  always_comb begin
    grant_l = l.req & (~c.req | ((CPU_PRIORITY == 1'b0) & (last_grant == PORT_C)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= PORT_C;
      last_grant <= PORT_L;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      c_rdata_q  <= '0;
      l_rdata_q  <= '0;
      c_err_q    <= 1'b0;
      l_err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (c.req | l.req) begin
            owner      <= grant_l;
            last_grant <= grant_l;
            lat_we     <= grant_l ? l.we    : c.we;
            lat_addr   <= grant_l ? l.addr  : c.addr;
            lat_wdata  <= grant_l ? l.wdata : c.wdata;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          // Writes leave the owner's rdata untouched; err is captured for both.
          if (owner == PORT_C) begin
            if (!lat_we) c_rdata_q <= read_data;
            c_err_q <= dmem_err;
          end else begin
            if (!lat_we) l_rdata_q <= read_data;
            l_err_q <= dmem_err;
          end
          state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_addr  = lat_addr;
  assign read_addr = lat_addr;
  assign mem_data  = lat_wdata;
  // Out-of-range writes are suppressed here so they never reach the array.
  assign mem_write = (state == ACCESS) & lat_we & ~dmem_err;

  // Decoded from state so a reset drops them immediately.
  assign c.ack   = (state == RESP) & (owner == PORT_C);
  assign l.ack   = (state == RESP) & (owner == PORT_L);
  assign c.rdata = c_rdata_q;
  assign l.rdata = l_rdata_q;
  assign c.err   = c_err_q;
  assign l.err   = l_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  typedef struct {
    bit          we;
    logic [63:0] addr;
    logic [63:0] wdata;
  } rq_t;

  typedef struct {
    bit          port;
    int          cyc;
    logic [63:0] rd;
    logic        er;
    logic [63:0] other;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dmem_arbiter_if ci0 ();
  dmem_arbiter_if li0 ();
  dmem_arbiter_if ci1 ();
  dmem_arbiter_if li1 ();

  logic [63:0] m0_addr, m0_raddr, m0_data, m0_rdat;
  logic [63:0] m1_addr, m1_raddr, m1_data, m1_rdat;
  logic        m0_we, m0_err, m1_we, m1_err;

  dmem_arbiter #(.CPU_PRIORITY(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .c(ci0), .l(li0),
    .mem_addr(m0_addr), .read_addr(m0_raddr), .mem_data(m0_data), .mem_write(m0_we),
    .read_data(m0_rdat), .dmem_err(m0_err)
  );

  dmem_arbiter #(.CPU_PRIORITY(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .c(ci1), .l(li1),
    .mem_addr(m1_addr), .read_addr(m1_raddr), .mem_data(m1_data), .mem_write(m1_we),
    .read_data(m1_rdat), .dmem_err(m1_err)
  );

  // dmem models: 1024 bytes, little-endian qwords, range error when addr+8 > 1024.
  logic [7:0] mem0 [1024];
  logic [7:0] mem1 [1024];
  bit loaded = 1'b0;

  function automatic logic [7:0] pat(int i);
    return 8'((i * 13 + 5) & 255);
  endfunction

  function automatic logic [63:0] pat_q(int a);
    logic [63:0] q;
    for (int j = 0; j < 8; j++) q[8*j +: 8] = pat(a + j);
    return q;
  endfunction

  assign m0_err = (m0_addr > 64'd1016);
  assign m1_err = (m1_addr > 64'd1016);

  always_comb begin
    m0_rdat = '0;
    m1_rdat = '0;
    for (int i = 0; i < 8; i++) begin
      if (int'(m0_raddr[9:0]) + i < 1024 && m0_raddr <= 64'd1016) m0_rdat[8*i +: 8] = mem0[int'(m0_raddr[9:0]) + i];
      if (int'(m1_raddr[9:0]) + i < 1024 && m1_raddr <= 64'd1016) m1_rdat[8*i +: 8] = mem1[int'(m1_raddr[9:0]) + i];
    end
  end

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 1024; i++) begin
        mem0[i] <= pat(i);
        mem1[i] <= pat(i);
      end
      loaded <= 1'b1;
    end else begin
      if (m0_we) for (int i = 0; i < 8; i++) mem0[int'(m0_addr[9:0]) + i] <= m0_data[8*i +: 8];
      if (m1_we) for (int i = 0; i < 8; i++) mem1[int'(m1_addr[9:0]) + i] <= m1_data[8*i +: 8];
    end
  end

  function automatic logic [63:0] memq(bit inst, int a);
    logic [63:0] q;
    for (int j = 0; j < 8; j++) q[8*j +: 8] = inst ? mem1[a + j] : mem0[a + j];
    return q;
  endfunction

  // Uniform views of both instances for sampling.
  logic        ack_s [2][2];
  logic [63:0] rd_s  [2][2];
  logic        er_s  [2][2];
  logic        wr_s  [2];
  assign ack_s[0][0] = ci0.ack;   assign ack_s[0][1] = li0.ack;
  assign ack_s[1][0] = ci1.ack;   assign ack_s[1][1] = li1.ack;
  assign rd_s[0][0]  = ci0.rdata; assign rd_s[0][1]  = li0.rdata;
  assign rd_s[1][0]  = ci1.rdata; assign rd_s[1][1]  = li1.rdata;
  assign er_s[0][0]  = ci0.err;   assign er_s[0][1]  = li0.err;
  assign er_s[1][0]  = ci1.err;   assign er_s[1][1]  = li1.err;
  assign wr_s[0]     = m0_we;     assign wr_s[1]     = m1_we;

  // Reference model: qword memory image, per-port result registers, round-robin memory.
  logic [63:0] ref_m  [2][128];
  logic [63:0] exp_rd [2][2];
  logic        exp_er [2][2];
  bit          m_last_l [2];
  ev_t         exp_ev[$];
  int          exp_wr;
  rq_t         cq[$];
  rq_t         lq[$];

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic rq_t mk(bit we, logic [63:0] addr, logic [63:0] wdata);
    rq_t r;
    r.we = we; r.addr = addr; r.wdata = wdata;
    return r;
  endfunction

  function automatic rq_t rand_rq();
    rq_t r;
    int  s;
    s       = $urandom_range(0, 9);
    r.we    = 1'($urandom_range(0, 1));
    r.wdata = {$urandom, $urandom};
    if (s == 0)      r.addr = 64'd1017 + 64'($urandom_range(0, 200));
    else if (s == 1) r.addr = 64'd1016;
    else             r.addr = 64'(8 * $urandom_range(0, 7));
    return r;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_last_l[i] = 1'b1;
      for (int p = 0; p < 2; p++) begin
        exp_rd[i][p] = '0;
        exp_er[i][p] = 1'b0;
      end
    end
  endfunction

  // Predicts the ack sequence: slot k completes at cycle 2+3k after the requests appear.
  task automatic predict(input bit inst);
    rq_t a[$];
    rq_t b[$];
    int  k;
    a = cq; b = lq; k = 0;
    exp_ev.delete();
    exp_wr = 0;
    while (a.size() > 0 || b.size() > 0) begin
      bit  pl;
      bit  err;
      rq_t r;
      ev_t e;
      if (a.size() == 0)      pl = 1'b1;
      else if (b.size() == 0) pl = 1'b0;
      else if (inst)          pl = 1'b0;
      else                    pl = ~m_last_l[inst];
      m_last_l[inst] = pl;
      if (pl) begin r = b[0]; b.delete(0); end
      else    begin r = a[0]; a.delete(0); end
      err = (r.addr > 64'd1016);
      if (r.we) begin
        if (!err) begin
          ref_m[inst][r.addr[9:3]] = r.wdata;
          exp_wr++;
        end
      end else begin
        exp_rd[inst][pl] = err ? 64'd0 : ref_m[inst][r.addr[9:3]];
      end
      exp_er[inst][pl] = err;
      e.port = pl; e.cyc = 2 + 3 * k; e.rd = exp_rd[inst][pl];
      e.er = err;  e.other = exp_rd[inst][~pl];
      exp_ev.push_back(e);
      k++;
    end
  endtask

  task automatic drive(input bit inst, input bit port, input bit req, input rq_t r);
    case ({inst, port})
      2'b00: begin ci0.req = req; ci0.we = r.we; ci0.addr = r.addr; ci0.wdata = r.wdata; end
      2'b01: begin li0.req = req; li0.we = r.we; li0.addr = r.addr; li0.wdata = r.wdata; end
      2'b10: begin ci1.req = req; ci1.we = r.we; ci1.addr = r.addr; ci1.wdata = r.wdata; end
      default: begin li1.req = req; li1.we = r.we; li1.addr = r.addr; li1.wdata = r.wdata; end
    endcase
  endtask

  // Plays cq/lq on one instance, presenting each port's next request on its ack edge.
  task automatic run(input bit inst);
    ev_t ob[$];
    ev_t e;
    rq_t z;
    int  wr;
    int  budget;
    z = mk(1'b0, 64'd0, 64'd0);
    predict(inst);
    budget = 3 * (cq.size() + lq.size()) + 4;
    wr = 0;
    @(posedge clk); #1;
    if (cq.size() > 0) drive(inst, 1'b0, 1'b1, cq[0]); else drive(inst, 1'b0, 1'b0, z);
    if (lq.size() > 0) drive(inst, 1'b1, 1'b1, lq[0]); else drive(inst, 1'b1, 1'b0, z);
    for (int cyc = 0; cyc < budget; cyc++) begin
      bit ac, al;
      @(negedge clk);
      if (wr_s[inst]) wr++;
      ac = ack_s[inst][0];
      al = ack_s[inst][1];
      if (ac) begin
        e.port = 1'b0; e.cyc = cyc; e.rd = rd_s[inst][0]; e.er = er_s[inst][0]; e.other = rd_s[inst][1];
        ob.push_back(e);
      end
      if (al) begin
        e.port = 1'b1; e.cyc = cyc; e.rd = rd_s[inst][1]; e.er = er_s[inst][1]; e.other = rd_s[inst][0];
        ob.push_back(e);
      end
      @(posedge clk); #1;
      if (ac && cq.size() > 0) begin
        cq.delete(0);
        if (cq.size() > 0) drive(inst, 1'b0, 1'b1, cq[0]); else drive(inst, 1'b0, 1'b0, z);
      end
      if (al && lq.size() > 0) begin
        lq.delete(0);
        if (lq.size() > 0) drive(inst, 1'b1, 1'b1, lq[0]); else drive(inst, 1'b1, 1'b0, z);
      end
    end
    drive(inst, 1'b0, 1'b0, z);
    drive(inst, 1'b1, 1'b0, z);
    chk("ack_count", 64'(ob.size()), 64'(exp_ev.size()));
    chk("write_cycles", 64'(wr), 64'(exp_wr));
    for (int i = 0; i < exp_ev.size() && i < ob.size(); i++) begin
      chk($sformatf("ack_port[%0d]", i), 64'(ob[i].port), 64'(exp_ev[i].port));
      chk($sformatf("ack_cyc[%0d]", i), 64'(ob[i].cyc), 64'(exp_ev[i].cyc));
      chk($sformatf("rdata[%0d]", i), ob[i].rd, exp_ev[i].rd);
      chk($sformatf("err[%0d]", i), 64'(ob[i].er), 64'(exp_ev[i].er));
      chk($sformatf("other_rdata[%0d]", i), ob[i].other, exp_ev[i].other);
    end
    cq.delete();
    lq.delete();
  endtask

  initial begin
    rq_t z;
    z = mk(1'b0, 64'd0, 64'd0);
    for (int i = 0; i < 128; i++) begin
      ref_m[0][i] = pat_q(8 * i);
      ref_m[1][i] = pat_q(8 * i);
    end
    model_reset();
    for (int i = 0; i < 2; i++) begin
      drive(i[0], 1'b0, 1'b0, z);
      drive(i[0], 1'b1, 1'b0, z);
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_c_ack", 64'(ci0.ack), 64'd0);
    chk("rst_l_ack", 64'(li0.ack), 64'd0);
    chk("rst_mem_write", 64'(m0_we), 64'd0);
    chk("rst_c_rdata", ci0.rdata, 64'd0);
    chk("rst_l_err", 64'(li0.err), 64'd0);
    chk("rst_mem_addr", m0_addr, 64'd0);
    chk("rst_read_addr", m0_raddr, 64'd0);
    chk("rst_mem_data", m1_data, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Port C write then read at 16.
    cq.push_back(mk(1'b1, 64'd16, 64'h1122334455667788));
    run(1'b0);
    cq.push_back(mk(1'b0, 64'd16, 64'd0));
    run(1'b0);
    chk("c_rdata_16", ci0.rdata, 64'h1122334455667788);

    // Round-robin tie held for four transactions.
    cq.push_back(mk(1'b0, 64'd0, 64'd0));
    cq.push_back(mk(1'b0, 64'd0, 64'd0));
    lq.push_back(mk(1'b0, 64'd8, 64'd0));
    lq.push_back(mk(1'b0, 64'd8, 64'd0));
    run(1'b0);

    // Range error: write at 1017 suppressed, 1016 is legal.
    lq.push_back(mk(1'b1, 64'd1017, 64'hDEADBEEFCAFEF00D));
    run(1'b0);
    chk("mem_1016_kept", memq(1'b0, 1016), ref_m[0][127]);
    lq.push_back(mk(1'b0, 64'd1016, 64'd0));
    run(1'b0);

    // Fixed priority: C held for three transactions starves L until it drops.
    cq.push_back(mk(1'b0, 64'd0, 64'd0));
    cq.push_back(mk(1'b1, 64'd24, 64'h0123456789ABCDEF));
    cq.push_back(mk(1'b0, 64'd24, 64'd0));
    lq.push_back(mk(1'b0, 64'd8, 64'd0));
    run(1'b1);

    // Reset in the middle of ACCESS of a C write to 32.
    cq.push_back(mk(1'b1, 64'd32, 64'hA5A5A5A55A5A5A5A));
    run(1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b1, mk(1'b1, 64'd32, 64'h0BADF00D0BADF00D));
    @(posedge clk); #2;
    chk("pre_rst_mem_write", 64'(m0_we), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_write", 64'(m0_we), 64'd0);
    chk("midrst_c_ack", 64'(ci0.ack), 64'd0);
    chk("midrst_l_ack", 64'(li0.ack), 64'd0);
    chk("midrst_mem_addr", m0_addr, 64'd0);
    chk("midrst_l_rdata", li0.rdata, 64'd0);
    drive(1'b0, 1'b0, 1'b0, z);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("mem_32_kept", memq(1'b0, 32), ref_m[0][4]);
    cq.push_back(mk(1'b0, 64'd32, 64'd0));
    lq.push_back(mk(1'b0, 64'd8, 64'd0));
    run(1'b0);

    // Random mixes on both instances.
    for (int it = 0; it < 30; it++) begin
      bit inst;
      int nc, nl;
      inst = 1'($urandom_range(0, 1));
      nc   = $urandom_range(0, 2);
      nl   = $urandom_range((nc == 0) ? 1 : 0, 2);
      for (int j = 0; j < nc; j++) cq.push_back(rand_rq());
      for (int j = 0; j < nl; j++) lq.push_back(rand_rq());
      run(inst);
    end
    for (int a = 0; a < 64; a += 8) begin
      chk($sformatf("final_mem0_%0d", a), memq(1'b0, a), ref_m[0][a/8]);
      chk($sformatf("final_mem1_%0d", a), memq(1'b1, a), ref_m[1][a/8]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
